// File: rtl/sa_ram_rwsp_160x65_rdctl.sv
// FIFO controller for an external 160x65 single-port-read / single-port-write RAM.
// Writes go straight to the RAM; reads run through a two-stage pipeline (address latch, output register).
module sa_ram_rwsp_160x65_rdctl #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 65,
  parameter int AW    = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [CW-1:0]    occ,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ_q;
  logic [CW-1:0] unread;
  logic          vld_p1;
  logic          vld_p2;
  logic          accept;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness uses the registered count only; a same-cycle ore never frees a slot early.
  assign wr_prdy = (occ_q < CW'(DEPTH));
  assign accept  = wr_pvld & wr_prdy & reset_;

  assign ram_we  = accept;
  assign ram_wa  = wr_ptr;
  assign ram_di  = wr_pd;

  assign ram_ore = vld_p1 & (!vld_p2 | rd_prdy);
  assign ram_re  = (unread != '0) & (!vld_p1 | ram_ore);
  assign ram_ra  = rd_ptr;

  assign rd_pvld = vld_p2;
  assign rd_pd   = ram_dout;
  assign occ     = occ_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      unread <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, ram_ore})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
      case ({accept, ram_re})
        2'b10:   unread <= unread + CW'(1);
        2'b01:   unread <= unread - CW'(1);
        default: unread <= unread;
      endcase
    end
  end

  // Stage 1: address latched in RAM; stage 2: data held in the RAM output register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= ram_re | (vld_p1 & !ram_ore);
      vld_p2 <= ram_ore | (vld_p2 & !rd_prdy);
    end
  end

endmodule
